// File: rtl/instr_mem_pipe.sv
// Instruction RAM with a req/gnt/rvalid fetch port, a pipelined read path and a program-load port.
// Optional build macro INSTR_MEM_ALIGN_CHECK_EN turns misaligned fetches into error responses.
module instr_mem_pipe #(
    parameter int          DEPTH_WORDS  = 256,
    parameter int          READ_LATENCY = 1,
    parameter logic [31:0] NOP_WORD     = 32'h0000_0013
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           instr_req_i,
    input  logic [31:0]                    instr_addr_i,
    output logic                           instr_gnt_o,
    output logic                           instr_rvalid_o,
    output logic [31:0]                    instr_rdata_o,
    output logic                           instr_err_o,
    input  logic                           prog_mode_i,
    input  logic                           prog_we_i,
    input  logic [$clog2(DEPTH_WORDS)-1:0] prog_addr_i,
    input  logic [31:0]                    prog_wdata_i,
    output logic                           busy_o
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = $clog2(READ_LATENCY + 1);

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_DRAIN = 2'd1,
        S_LOAD  = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [CW-1:0]       busy_q, busy_d;
    logic [31:0]         mem [DEPTH_WORDS];
    logic                vld_q  [READ_LATENCY];
    logic                err_q  [READ_LATENCY];
    logic [31:0]         data_q [READ_LATENCY];

    logic [AW-1:0]       word_idx;
    logic                out_of_range;
    logic                misaligned;
    logic                fetch_err;
    logic                mem_we;

    assign instr_gnt_o  = instr_req_i & ~prog_mode_i & ~rst;
    assign word_idx     = instr_addr_i[AW+1:2];
    assign out_of_range = |instr_addr_i[31:AW+2];

`ifdef INSTR_MEM_ALIGN_CHECK_EN
    assign misaligned = |instr_addr_i[1:0];
`else
    logic addr_lsb_unused;
    assign addr_lsb_unused = ^instr_addr_i[1:0];
    assign misaligned      = 1'b0;
`endif

    assign fetch_err = out_of_range | misaligned;

    // Writes land only once the load FSM has confirmed no fetch is still in flight.
    assign mem_we = prog_mode_i & prog_we_i & (state_q == S_LOAD);

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[prog_addr_i] <= prog_wdata_i;
        end
    end

    // Stage 0 is the RAM read register; later stages only move when fed a valid
    // entry, so the last stage naturally holds the previous response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < READ_LATENCY; i++) begin
                vld_q[i]  <= 1'b0;
                err_q[i]  <= 1'b0;
                data_q[i] <= '0;
            end
        end else begin
            vld_q[0] <= instr_gnt_o;
            if (instr_gnt_o) begin
                err_q[0]  <= fetch_err;
                data_q[0] <= mem[word_idx];
            end
            for (int i = 0; i < READ_LATENCY - 1; i++) begin
                vld_q[i+1] <= vld_q[i];
                if (vld_q[i]) begin
                    err_q[i+1]  <= err_q[i];
                    data_q[i+1] <= data_q[i];
                end
            end
        end
    end

    assign instr_rvalid_o = vld_q[READ_LATENCY-1];
    assign instr_err_o    = err_q[READ_LATENCY-1];
    assign instr_rdata_o  = err_q[READ_LATENCY-1] ? NOP_WORD : data_q[READ_LATENCY-1];

    always_comb begin
        busy_d = busy_q;
        case ({instr_gnt_o, instr_rvalid_o})
            2'b10:   busy_d = busy_q + CW'(1);
            2'b01:   busy_d = busy_q - CW'(1);
            default: busy_d = busy_q;
        endcase
    end

    assign busy_o = (busy_q != '0);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RUN: begin
                if (prog_mode_i) begin
                    state_d = busy_o ? S_DRAIN : S_LOAD;
                end
            end
            S_DRAIN: begin
                if (!prog_mode_i) begin
                    state_d = S_RUN;
                end else if (!busy_o) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                if (!prog_mode_i) begin
                    state_d = S_RUN;
                end
            end
            default: state_d = S_RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_RUN;
            busy_q  <= '0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
        end
    end

endmodule

// File: tb/tb_instr_mem_pipe.sv
// Self-checking bench for instr_mem_pipe: directed scenarios followed by random traffic,
// checked cycle by cycle against a queue-based response model.
module tb_instr_mem_pipe;

    localparam int          DEPTH = 256;
    localparam int          LAT   = 3;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic        instr_req_i;
    logic [31:0] instr_addr_i;
    logic        instr_gnt_o;
    logic        instr_rvalid_o;
    logic [31:0] instr_rdata_o;
    logic        instr_err_o;
    logic        prog_mode_i;
    logic        prog_we_i;
    logic [7:0]  prog_addr_i;
    logic [31:0] prog_wdata_i;
    logic        busy_o;

    instr_mem_pipe #(
        .DEPTH_WORDS (DEPTH),
        .READ_LATENCY(LAT),
        .NOP_WORD    (NOP)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .instr_req_i   (instr_req_i),
        .instr_addr_i  (instr_addr_i),
        .instr_gnt_o   (instr_gnt_o),
        .instr_rvalid_o(instr_rvalid_o),
        .instr_rdata_o (instr_rdata_o),
        .instr_err_o   (instr_err_o),
        .prog_mode_i   (prog_mode_i),
        .prog_we_i     (prog_we_i),
        .prog_addr_i   (prog_addr_i),
        .prog_wdata_i  (prog_wdata_i),
        .busy_o        (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic        err;
        logic [31:0] data;
    } rsp_t;

    rsp_t        exp_q[$];
    logic [31:0] ref_mem [DEPTH];
    int          cyc;
    int          n_cmp;
    int          n_bad;
    logic [31:0] last_data;
    logic        last_err;
    bit          seen_idle;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, check every output, advance the model.
    task automatic step(input logic req, input logic [31:0] addr, input logic mode,
                        input logic we, input logic [7:0] waddr, input logic [31:0] wdata);
        rsp_t        r;
        bit          busy_exp;
        logic [29:0] idx;
        bit          e;
        instr_req_i  = req;
        instr_addr_i = addr;
        prog_mode_i  = mode;
        prog_we_i    = we;
        prog_addr_i  = waddr;
        prog_wdata_i = wdata;
        #1;
        busy_exp = (exp_q.size() != 0);
        chk("busy", {31'd0, busy_o}, {31'd0, busy_exp});
        chk("gnt", {31'd0, instr_gnt_o}, {31'd0, req & ~mode});
        if (exp_q.size() != 0 && exp_q[0].due == cyc) begin
            chk("rvalid", {31'd0, instr_rvalid_o}, 32'd1);
            chk("rdata", instr_rdata_o, exp_q[0].data);
            chk("err", {31'd0, instr_err_o}, {31'd0, exp_q[0].err});
            last_data = exp_q[0].data;
            last_err  = exp_q[0].err;
            void'(exp_q.pop_front());
        end else begin
            chk("no_rvalid", {31'd0, instr_rvalid_o}, 32'd0);
            chk("hold_rdata", instr_rdata_o, last_data);
            chk("hold_err", {31'd0, instr_err_o}, {31'd0, last_err});
        end
        if (req && !mode) begin
            idx = addr[31:2];
            e   = (idx >= 30'(DEPTH));
`ifdef INSTR_MEM_ALIGN_CHECK_EN
            if (addr[1:0] != 2'b00) e = 1'b1;
`endif
            r.due  = cyc + LAT;
            r.err  = e;
            r.data = e ? NOP : ref_mem[idx[7:0]];
            exp_q.push_back(r);
        end
        if (mode && we && seen_idle) ref_mem[waddr] = wdata;
        if (!mode) seen_idle = 1'b0;
        else if (!busy_exp) seen_idle = 1'b1;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n, input logic mode);
        for (int k = 0; k < n; k++) step(1'b0, 32'd0, mode, 1'b0, 8'd0, 32'd0);
    endtask

    task automatic do_reset();
        instr_req_i = 1'b1;
        prog_mode_i = 1'b0;
        prog_we_i   = 1'b0;
        rst         = 1'b1;
        #1;
        chk("rst_rvalid", {31'd0, instr_rvalid_o}, 32'd0);
        chk("rst_rdata", instr_rdata_o, 32'd0);
        chk("rst_err", {31'd0, instr_err_o}, 32'd0);
        chk("rst_busy", {31'd0, busy_o}, 32'd0);
        chk("rst_gnt", {31'd0, instr_gnt_o}, 32'd0);
        exp_q.delete();
        last_data = 32'd0;
        last_err  = 1'b0;
        seen_idle = 1'b0;
        @(posedge clk);
        #1;
        rst         = 1'b0;
        instr_req_i = 1'b0;
        @(posedge clk);
        #1;
        cyc += 2;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout observed=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] a;
        bit          mode_r;
        int          sel;
        rst = 1'b1; instr_req_i = 1'b0; instr_addr_i = 32'd0; prog_mode_i = 1'b0;
        prog_we_i = 1'b0; prog_addr_i = 8'd0; prog_wdata_i = 32'd0;
        cyc = 0; n_cmp = 0; n_bad = 0; last_data = 32'd0; last_err = 1'b0; seen_idle = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // Program the whole RAM, then word 5.
        step(1'b0, 32'd0, 1'b1, 1'b1, 8'd3, 32'hFFFF_0000);
        for (int i = 0; i < DEPTH; i++) step(1'b0, 32'd0, 1'b1, 1'b1, 8'(i), $urandom());
        step(1'b0, 32'd0, 1'b1, 1'b1, 8'd5, 32'hDEAD_BEEF);
        idle(1, 1'b0);

        // Latency
        step(1'b1, 32'h14, 1'b0, 1'b0, 8'd0, 32'd0);
        idle(LAT + 1, 1'b0);

        // Streaming
        for (int i = 0; i < 8; i++) step(1'b1, 32'(i * 4), 1'b0, 1'b0, 8'd0, 32'd0);
        idle(LAT + 1, 1'b0);

        // Out of range
        step(1'b1, 32'h400, 1'b0, 1'b0, 8'd0, 32'd0);
        idle(LAT + 1, 1'b0);

        // Drain then load
        step(1'b1, 32'h20, 1'b0, 1'b0, 8'd0, 32'd0);
        step(1'b1, 32'h24, 1'b0, 1'b0, 8'd0, 32'd0);
        step(1'b1, 32'h30, 1'b1, 1'b1, 8'd9, 32'hBAD0_0001);
        step(1'b1, 32'h30, 1'b1, 1'b1, 8'd10, 32'hBAD0_0002);
        idle(3, 1'b1);
        step(1'b0, 32'd0, 1'b1, 1'b1, 8'd10, 32'h600D_000A);
        step(1'b1, 32'h24, 1'b0, 1'b0, 8'd0, 32'd0);
        step(1'b1, 32'h28, 1'b0, 1'b0, 8'd0, 32'd0);
        idle(LAT + 1, 1'b0);

        // Reset with fetches in flight
        step(1'b1, 32'h0, 1'b0, 1'b0, 8'd0, 32'd0);
        step(1'b1, 32'h4, 1'b0, 1'b0, 8'd0, 32'd0);
        step(1'b1, 32'h8, 1'b0, 1'b0, 8'd0, 32'd0);
        do_reset();
        idle(LAT + 2, 1'b0);
        step(1'b1, 32'h14, 1'b0, 1'b0, 8'd0, 32'd0);
        step(1'b1, 32'h4, 1'b0, 1'b0, 8'd0, 32'd0);
        idle(LAT + 1, 1'b0);

        // Misaligned
        step(1'b1, 32'h6, 1'b0, 1'b0, 8'd0, 32'd0);
        idle(LAT + 1, 1'b0);

        // Random traffic
        mode_r = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 15) == 0) mode_r = ~mode_r;
            sel = $urandom_range(0, 19);
            a   = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
            if (sel == 0) begin
                a = $urandom();
                a[1:0] = 2'b00;
                if (a[31:10] == 22'd0) a[20] = 1'b1;
            end else if (sel == 1) begin
                a[1:0] = 2'($urandom_range(1, 3));
            end
            step(($urandom_range(0, 3) != 0), a, mode_r, 1'($urandom()),
                 8'($urandom_range(0, 255)), $urandom());
        end
        idle(LAT + 2, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
